// File: rtl/psram_arbiter_if.sv
// Bus bundle between the two line requesters, the arbiter and the PSRAM controller.
// slave = arbiter view, master = requesters plus controller (environment) view.
interface psram_arbiter_if;
   logic         p0_req;
   logic         p0_we;
   logic [17:0]  p0_addr;
   logic [127:0] p0_rdata;
   logic         p0_cache_en;
   logic         p0_cache_we;
   logic         p0_done;

   logic         p1_req;
   logic         p1_we;
   logic [17:0]  p1_addr;
   logic [127:0] p1_rdata;
   logic         p1_cache_en;
   logic         p1_cache_we;
   logic         p1_done;

   logic [1:0]   grant;
   logic         mem_rd;
   logic         mem_wr;
   logic [17:0]  raddr;
   logic [17:0]  waddr;
   logic [127:0] cache_rdata;
   logic         cache_en;
   logic         cache_we;
   logic         rd_busy;
   logic         wr_busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_rdata,
      input  p1_req, p1_we, p1_addr, p1_rdata,
      input  cache_en, cache_we, rd_busy, wr_busy,
      output p0_cache_en, p0_cache_we, p0_done,
      output p1_cache_en, p1_cache_we, p1_done,
      output grant, mem_rd, mem_wr, raddr, waddr, cache_rdata
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_rdata,
      output p1_req, p1_we, p1_addr, p1_rdata,
      output cache_en, cache_we, rd_busy, wr_busy,
      input  p0_cache_en, p0_cache_we, p0_done,
      input  p1_cache_en, p1_cache_we, p1_done,
      input  grant, mem_rd, mem_wr, raddr, waddr, cache_rdata
   );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port line arbiter/sequencer in front of the QSPI PSRAM cache-line controller.
// Define PSRAM_ARB_STATS_EN to add per-port completion counters and a max-wait statistic.
module psram_arbiter #(
   parameter int P1_MAX_BURST = 4
`ifdef PSRAM_ARB_STATS_EN
   ,
   parameter int STAT_W = 32
`endif
) (
   input  logic mem_clk,
   input  logic reset_n,
   psram_arbiter_if.slave bus
`ifdef PSRAM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] p0_grants,
   output logic [STAT_W-1:0] p1_grants,
   output logic [STAT_W-1:0] max_wait
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [1:0]   grant_q, grant_d;
   logic         we_q, we_d;
   logic [17:0]  addr_q, addr_d;
   logic [1:0]   done_q, done_d;
   logic [3:0]   burst_q, burst_d;
   logic         busy;
   logic         force_p0;

   assign busy     = bus.rd_busy | bus.wr_busy;
   assign force_p0 = bus.p0_req && (burst_q >= 4'(P1_MAX_BURST));

   always_ff @(posedge mem_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         we_q    <= 1'b0;
         addr_q  <= 18'd0;
         done_q  <= 2'b00;
         burst_q <= 4'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      we_d    = we_q;
      addr_d  = addr_q;
      done_d  = 2'b00;
      burst_d = burst_q;
      case (state_q)
         IDLE: begin
            // The done cycle itself never arbitrates, so a requester may still drop req one cycle later.
            if (done_q == 2'b00) begin
               if (bus.p1_req && !force_p0) begin
                  grant_d = 2'b10;
                  we_d    = bus.p1_we;
                  addr_d  = bus.p1_addr;
                  burst_d = bus.p0_req ? burst_q + 4'd1 : 4'd0;
                  state_d = ISSUE;
               end else if (bus.p0_req) begin
                  grant_d = 2'b01;
                  we_d    = bus.p0_we;
                  addr_d  = bus.p0_addr;
                  burst_d = 4'd0;
                  state_d = ISSUE;
               end else begin
                  burst_d = 4'd0;
               end
            end
         end
         ISSUE: begin
            // No timeout: the controller stays idle through its long power-up init.
            if (busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!busy) begin
               done_d  = grant_q;
               grant_d = 2'b00;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_comb begin
      bus.mem_rd      = (state_q == ISSUE) && !we_q;
      bus.mem_wr      = (state_q == ISSUE) && we_q;
      bus.grant       = grant_q;
      bus.raddr       = addr_q;
      bus.waddr       = addr_q;
      bus.p0_done     = done_q[0];
      bus.p1_done     = done_q[1];
      bus.cache_rdata = grant_q[1] ? bus.p1_rdata : bus.p0_rdata;
      bus.p0_cache_en = bus.cache_en & grant_q[0];
      bus.p0_cache_we = bus.cache_we & grant_q[0];
      bus.p1_cache_en = bus.cache_en & grant_q[1];
      bus.p1_cache_we = bus.cache_we & grant_q[1];
   end

`ifdef PSRAM_ARB_STATS_EN
   logic [1:0]        req_w;
   logic [STAT_W-1:0] max_wait_q, max_wait_d;

   assign req_w = {bus.p1_req, bus.p0_req};

   for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [STAT_W-1:0] grants_q;
      logic [STAT_W-1:0] wait_q;
      logic              waiting;

      // A request is waiting until its transaction reaches WAIT_DONE.
      assign waiting = req_w[gi] && !done_q[gi] && !((state_q == WAIT_DONE) && grant_q[gi]);

      always_ff @(posedge mem_clk or negedge reset_n) begin
         if (!reset_n) begin
            grants_q <= '0;
            wait_q   <= '0;
         end else begin
            if (done_d[gi] && (grants_q != '1)) begin
               grants_q <= grants_q + 1'b1;
            end
            if (!waiting) begin
               wait_q <= '0;
            end else if (wait_q != '1) begin
               wait_q <= wait_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      max_wait_d = max_wait_q;
      if (g_stat[0].wait_q > max_wait_d) max_wait_d = g_stat[0].wait_q;
      if (g_stat[1].wait_q > max_wait_d) max_wait_d = g_stat[1].wait_q;
   end

   always_ff @(posedge mem_clk or negedge reset_n) begin
      if (!reset_n) begin
         max_wait_q <= '0;
      end else begin
         max_wait_q <= max_wait_d;
      end
   end

   assign p0_grants = g_stat[0].grants_q;
   assign p1_grants = g_stat[1].grants_q;
   assign max_wait  = max_wait_q;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with an inline controller model driving rd_busy/wr_busy.
module tb_psram_arbiter;
   logic clk;
   logic rst_n;
   int   vecs;
   int   errs;
   int   exp_p0_cnt;
   int   exp_p1_cnt;
   string cur;

   psram_arbiter_if bus ();

`ifdef PSRAM_ARB_STATS_EN
   logic [31:0] p0_grants, p1_grants, max_wait;
`endif

   psram_arbiter #(.P1_MAX_BURST(4)) dut (
      .mem_clk (clk),
      .reset_n (rst_n),
      .bus     (bus)
`ifdef PSRAM_ARB_STATS_EN
      ,
      .p0_grants (p0_grants),
      .p1_grants (p1_grants),
      .max_wait  (max_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp);
      end
   endtask

   // Controller model: wait for the request, raise busy after lat cycles, hold it for hold cycles.
   task automatic serve(input logic exp_we, input logic [1:0] exp_g, input logic [17:0] exp_addr,
                        input logic [127:0] exp_wd, input int lat, input int hold);
      int n;
      n = 0;
      while (!(bus.mem_rd || bus.mem_wr) && n < 20000) begin
         tick;
         n++;
      end
      check("issue_seen", (n < 20000), 1'b1);
      check("grant", bus.grant, exp_g);
      check("mem_wr", bus.mem_wr, exp_we);
      check("mem_rd", bus.mem_rd, !exp_we);
      check("raddr", bus.raddr, exp_addr);
      check("waddr", bus.waddr, exp_addr);
      repeat (lat) tick;
      check("req_held", bus.mem_rd | bus.mem_wr, 1'b1);
      bus.rd_busy = !exp_we;
      bus.wr_busy = exp_we;
      #1;
      check("req_until_busy", bus.mem_rd | bus.mem_wr, 1'b1);
      tick;
      check("req_cleared", {bus.mem_rd, bus.mem_wr}, 2'b00);
      for (int i = 0; i < hold - 1; i++) begin
         bus.cache_en = i[0];
         bus.cache_we = exp_we ? 1'b0 : i[1];
         #1;
         check("p0_cache_en", bus.p0_cache_en, bus.cache_en & exp_g[0]);
         check("p1_cache_en", bus.p1_cache_en, bus.cache_en & exp_g[1]);
         check("p0_cache_we", bus.p0_cache_we, bus.cache_we & exp_g[0]);
         check("p1_cache_we", bus.p1_cache_we, bus.cache_we & exp_g[1]);
         check("cache_rdata", bus.cache_rdata, exp_wd);
         check("grant_stable", bus.grant, exp_g);
         check("no_early_done", {bus.p1_done, bus.p0_done}, 2'b00);
         tick;
      end
      bus.cache_en = 1'b0;
      bus.cache_we = 1'b0;
      bus.rd_busy  = 1'b0;
      bus.wr_busy  = 1'b0;
      tick;
      check("done_owner", {bus.p1_done, bus.p0_done}, exp_g);
      check("grant_clear", bus.grant, 2'b00);
      if (exp_g[0]) exp_p0_cnt++;
      if (exp_g[1]) exp_p1_cnt++;
      $display("txn %s: grant=%b we=%b addr=%05h wait=%0d done=%b", cur, exp_g, exp_we, exp_addr, n,
               {bus.p1_done, bus.p0_done});
   endtask

   task automatic drop_and_idle;
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      tick;
      check("done_one_cycle", {bus.p1_done, bus.p0_done}, 2'b00);
      tick;
      check("idle_grant", bus.grant, 2'b00);
      check("idle_req", {bus.mem_rd, bus.mem_wr}, 2'b00);
   endtask

   logic [1:0] arb_exp [10];
   int bad;

   initial begin
      vecs = 0; errs = 0; exp_p0_cnt = 0; exp_p1_cnt = 0; cur = "reset";
      rst_n = 1'b0;
      bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_rdata = '0;
      bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_rdata = '0;
      bus.cache_en = 0; bus.cache_we = 0; bus.rd_busy = 0; bus.wr_busy = 0;
      tick; tick;
      check("grant", bus.grant, 2'b00);
      check("mem", {bus.mem_rd, bus.mem_wr}, 2'b00);
      check("raddr", bus.raddr, 18'h0);
      check("waddr", bus.waddr, 18'h0);
      check("done", {bus.p1_done, bus.p0_done}, 2'b00);
      rst_n = 1'b1;
      bus.rd_busy = 1'b1;
      tick; tick;
      check("busy_in_idle", {bus.mem_rd, bus.mem_wr, bus.grant}, 4'b0000);
      bus.rd_busy = 1'b0;
      tick;

      cur = "p0_read";
      bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 18'h00123;
      bus.p0_rdata = {4{32'h11223344}};
      serve(1'b0, 2'b01, 18'h00123, {4{32'h11223344}}, 2, 140);
      drop_and_idle;

      cur = "reset_mid";
      bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 18'h01555;
      tick;
      check("issue", bus.mem_rd, 1'b1);
      bus.rd_busy = 1'b1;
      tick; tick; tick;
      check("in_wait", {bus.mem_rd, bus.grant}, 3'b001);
      #2;
      rst_n = 1'b0;
      bus.rd_busy = 1'b0;
      #1;
      check("grant", bus.grant, 2'b00);
      check("mem", {bus.mem_rd, bus.mem_wr}, 2'b00);
      check("done", {bus.p1_done, bus.p0_done}, 2'b00);
      bus.p0_req = 0;
      exp_p0_cnt = 0; exp_p1_cnt = 0;
      tick;
      rst_n = 1'b1;
      tick; tick;
      check("no_done_after", {bus.p1_done, bus.p0_done, bus.grant}, 4'b0000);
      bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 18'h00ABC;
      serve(1'b1, 2'b01, 18'h00ABC, {4{32'h11223344}}, 1, 5);
      drop_and_idle;

      cur = "p0_write";
      bus.p0_rdata = {16{8'h0F}};
      bus.p1_rdata = {16{8'hA5}};
      bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 18'h3FFFF;
      serve(1'b1, 2'b01, 18'h3FFFF, {16{8'h0F}}, 2, 20);
      drop_and_idle;

      cur = "arb";
      arb_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 18'h0000A;
      bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 18'h1000B;
      for (int k = 0; k < 10; k++) begin
         if (arb_exp[k] == 2'b10)
            serve(1'b1, 2'b10, 18'h1000B, {16{8'hA5}}, 1, 3);
         else
            serve(1'b0, 2'b01, 18'h0000A, {16{8'h0F}}, 1, 3);
      end
      drop_and_idle;

      cur = "init";
      bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 18'h2AAAA;
      tick;
      bad = 0;
      for (int i = 0; i < 16384; i++) begin
         if (bus.mem_rd !== 1'b1 || bus.p1_done !== 1'b0 || bus.p0_done !== 1'b0) bad++;
         tick;
      end
      check("held_through_init", bad, 0);
      serve(1'b0, 2'b10, 18'h2AAAA, {16{8'hA5}}, 0, 10);
      drop_and_idle;

`ifdef PSRAM_ARB_STATS_EN
      cur = "stats";
      check("p0_grants", p0_grants, exp_p0_cnt);
      check("p1_grants", p1_grants, exp_p1_cnt);
      check("max_wait_ge_init", (max_wait >= 32'd16384), 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the QSPI PSRAM cache-line controller.
- Port 0 is the CPU cache; port 1 is the video/DMA line fetcher.
- Serialises 64-byte line read/write requests onto the controller's single mem_rd/mem_wr + rd_busy/wr_busy handshake.
- Steers the controller's 128-bit cache-side datapath to the granted port for the whole transaction.

Parameters:
- P1_MAX_BURST, 4, max consecutive port-1 grants while port 0 is pending before port 0 is forced in (1..15).
- STAT_W, 32, width of each statistics counter (optional feature only).

Ports:
- mem_clk  in  1  clock; arbiter logic on posedge (controller runs on negedge of the same clock)
- reset_n  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 request; held until p0_done
- p0_we  in  1  1 = line write, 0 = line read; stable while p0_req
- p0_addr  in  18  line address [23:6]; stable while p0_req
- p0_rdata  in  128  port 0 cache read data (source for PSRAM writes)
- p0_cache_en  out  1  controller cache_en gated to port 0
- p0_cache_we  out  1  controller cache_we gated to port 0
- p0_done  out  1  one-cycle completion pulse
- p1_req, p1_we, p1_addr, p1_rdata, p1_cache_en, p1_cache_we, p1_done: same as port 0, for port 1
- grant  out  2  one-hot owner; 2'b00 when idle
- mem_rd  out  1  controller read request
- mem_wr  out  1  controller write request
- raddr  out  18  controller read address
- waddr  out  18  controller write address
- cache_rdata  out  128  muxed write data to controller
- cache_en  in  1  from controller
- cache_we  in  1  from controller
- rd_busy  in  1  from controller
- wr_busy  in  1  from controller

Behaviour:
- Reset (async, reset_n=0): state=IDLE; grant=0; mem_rd=mem_wr=0; raddr=waddr=0; p0_done=p1_done=0; burst counter=0; latched we/addr=0.
- cache_rdata = grant[1] ? p1_rdata : p0_rdata (combinational).
- pN_cache_en = cache_en & grant[N]; pN_cache_we = cache_we & grant[N] (combinational).
- busy = rd_busy | wr_busy.
- FSM, three states:
  - IDLE:
    - No request: stay.
    - Arbitration picks the winner; next edge registers grant, latches we/addr into raddr and waddr (both driven with the same address), goes to ISSUE.
    - busy seen in IDLE is ignored.
  - ISSUE:
    - mem_wr=latched we, mem_rd=~latched we.
    - Hold until busy=1 sampled; that edge clears mem_rd/mem_wr and goes to WAIT_DONE.
    - No timeout: the controller ignores requests during its ~16K-cycle power-up init, so ISSUE simply waits.
  - WAIT_DONE:
    - On busy=0 sampled: one-cycle pN_done pulse to the owner, grant cleared, return to IDLE.
- Arbitration:
  - Port 1 has priority.
  - Burst counter increments on each port-1 grant made while p0_req=1.
  - At P1_MAX_BURST, port 0 wins the next arbitration even if p1_req=1; counter clears on any port-0 grant or when p0_req=0 at arbitration.
  - Simultaneous requests with counter < P1_MAX_BURST: port 1 wins.
- Minimum spacing: the done cycle is spent in WAIT_DONE→IDLE; a new grant is registered no earlier than the edge after done. A requester may drop req on the cycle after done or keep it high for a back-to-back request.
- Requester dropping req before done: protocol violation. The transaction still completes and done still pulses.
- grant, latched we and latched addr stay constant from grant to done.
- Controller and arbiter share the reset source. Reset mid-transaction aborts without a done pulse.

Optional Feature:
- Macro PSRAM_ARB_STATS_EN.
- Defined: adds outputs p0_grants, p1_grants (STAT_W, transactions completed per port, incremented on done) and max_wait (STAT_W, longest IDLE/ISSUE cycles seen by any pending request). All saturate at all-ones and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single p0 read, addr=18'h00123; controller model raises rd_busy 2 cycles after mem_rd, holds 140 cycles → mem_rd high until busy, raddr=18'h00123, grant=01, p0_cache_en mirrors cache_en, p0_done exactly 1 cycle after busy falls, grant=00 after.
- p0 write with p0_rdata=128'h0F..., addr=18'h3FFFF → mem_wr only, waddr=18'h3FFFF, cache_rdata equals p0_rdata for the whole transaction; p1_cache_en never asserts.
- p0 and p1 both request continuously, P1_MAX_BURST=4 → grant order 1,1,1,1,0,1,1,1,1,0; each done pulses only to its owner.
- p1_req asserted during controller init (busy held 0 for 16384 cycles) → mem_rd held the entire time with no done pulse; transaction completes after busy finally rises and falls.
- reset_n pulled low mid WAIT_DONE → mem_rd=mem_wr=0, grant=00, no done pulse; a fresh request after release completes normally.
- With PSRAM_ARB_STATS_EN, 3 p0 and 5 p1 transactions → p0_grants=3, p1_grants=5; without the macro, the build has no stats ports.
